// File: rtl/uart_frame_parser.sv
// Assembles SYNC/CMD/LEN/PAYLOAD/CHK frames from UART receiver bytes and
// presents validated frames as one parallel word with a single-cycle strobe.
module uart_frame_parser #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned MAXLEN         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100_000
) (
    input  logic                           clk,
    input  logic                           rstb,
    input  logic [7:0]                     rx_data,
    input  logic                           rx_valid,
    input  logic [1:0]                     rx_error,
    output logic                           frame_valid,
    output logic [7:0]                     frame_cmd,
    output logic [$clog2(MAXLEN+1)-1:0]    frame_len,
    output logic [MAXLEN*8-1:0]            frame_payload,
    output logic                           frame_error,
    output logic [2:0]                     error_code,
    output logic                           busy
);

    localparam int unsigned LW = $clog2(MAXLEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {StSync, StCmd, StLen, StPayload, StCheck} state_e;

    state_e              state_q, state_d;
    logic [MAXLEN*8-1:0] buf_q, buf_d;
    logic [LW-1:0]       idx_q, idx_d;
    logic [LW-1:0]       len_q, len_d;
    logic [7:0]          cmd_q, cmd_d;
    logic [7:0]          chk_q, chk_d;
    logic [TW-1:0]       cnt_q, cnt_d;
    logic                frame_valid_q, frame_valid_d;
    logic                frame_error_q, frame_error_d;
    logic [2:0]          error_code_q, error_code_d;
    logic [7:0]          frame_cmd_q, frame_cmd_d;
    logic [LW-1:0]       frame_len_q, frame_len_d;
    logic [MAXLEN*8-1:0] frame_payload_q, frame_payload_d;

    assign busy = (state_q != StSync);

    always_comb begin
        state_d         = state_q;
        buf_d           = buf_q;
        idx_d           = idx_q;
        len_d           = len_q;
        cmd_d           = cmd_q;
        chk_d           = chk_q;
        cnt_d           = cnt_q;
        frame_valid_d   = 1'b0;
        frame_error_d   = 1'b0;
        error_code_d    = error_code_q;
        frame_cmd_d     = frame_cmd_q;
        frame_len_d     = frame_len_q;
        frame_payload_d = frame_payload_q;

        // Priority: receiver error, then accepted byte, then timeout.
        if (busy && (rx_error != 2'd0)) begin
            state_d       = StSync;
            frame_error_d = 1'b1;
            error_code_d  = 3'd3;
        end else if (rx_valid) begin
            cnt_d = '0;
            case (state_q)
                StSync: begin
                    if (rx_data == SYNC_BYTE) begin
                        buf_d   = '0;
                        idx_d   = '0;
                        chk_d   = '0;
                        state_d = StCmd;
                    end
                end
                StCmd: begin
                    cmd_d   = rx_data;
                    chk_d   = rx_data;
                    state_d = StLen;
                end
                StLen: begin
                    if (rx_data > 8'(MAXLEN)) begin
                        state_d       = StSync;
                        frame_error_d = 1'b1;
                        error_code_d  = 3'd1;
                    end else begin
                        len_d   = rx_data[LW-1:0];
                        chk_d   = chk_q ^ rx_data;
                        state_d = (rx_data == 8'd0) ? StCheck : StPayload;
                    end
                end
                StPayload: begin
                    for (int i = 0; i < MAXLEN; i++) begin
                        if (idx_q == LW'(i)) buf_d[8*i +: 8] = rx_data;
                    end
                    chk_d = chk_q ^ rx_data;
                    idx_d = idx_q + LW'(1);
                    if ((idx_q + LW'(1)) == len_q) state_d = StCheck;
                end
                StCheck: begin
                    if (rx_data == chk_q) begin
                        frame_valid_d   = 1'b1;
                        error_code_d    = 3'd0;
                        frame_cmd_d     = cmd_q;
                        frame_len_d     = len_q;
                        frame_payload_d = buf_q;
                    end else begin
                        frame_error_d = 1'b1;
                        error_code_d  = 3'd2;
                    end
                    state_d = StSync;
                end
                default: state_d = StSync;
            endcase
        end else if (busy) begin
            if (cnt_q == TMAX) begin
                state_d       = StSync;
                frame_error_d = 1'b1;
                error_code_d  = 3'd4;
            end else begin
                cnt_d = cnt_q + TW'(1);
            end
        end

        if (state_d == StSync) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q         <= StSync;
            buf_q           <= '0;
            idx_q           <= '0;
            len_q           <= '0;
            cmd_q           <= '0;
            chk_q           <= '0;
            cnt_q           <= '0;
            frame_valid_q   <= 1'b0;
            frame_error_q   <= 1'b0;
            error_code_q    <= '0;
            frame_cmd_q     <= '0;
            frame_len_q     <= '0;
            frame_payload_q <= '0;
        end else begin
            state_q         <= state_d;
            buf_q           <= buf_d;
            idx_q           <= idx_d;
            len_q           <= len_d;
            cmd_q           <= cmd_d;
            chk_q           <= chk_d;
            cnt_q           <= cnt_d;
            frame_valid_q   <= frame_valid_d;
            frame_error_q   <= frame_error_d;
            error_code_q    <= error_code_d;
            frame_cmd_q     <= frame_cmd_d;
            frame_len_q     <= frame_len_d;
            frame_payload_q <= frame_payload_d;
        end
    end

    assign frame_valid   = frame_valid_q;
    assign frame_error   = frame_error_q;
    assign error_code    = error_code_q;
    assign frame_cmd     = frame_cmd_q;
    assign frame_len     = frame_len_q;
    assign frame_payload = frame_payload_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: table of frames plus hand-written
// timeout, receiver-error and reset sequences.
module tb_uart_frame_parser;

    localparam int T = 2000;

    logic        clk = 1'b0;
    logic        rstb;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [1:0]  rx_error;
    logic        frame_valid;
    logic [7:0]  frame_cmd;
    logic [3:0]  frame_len;
    logic [63:0] frame_payload;
    logic        frame_error;
    logic [2:0]  error_code;
    logic        busy;

    uart_frame_parser #(
        .SYNC_BYTE      (8'hA5),
        .MAXLEN         (8),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk           (clk),
        .rstb          (rstb),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_error      (rx_error),
        .frame_valid   (frame_valid),
        .frame_cmd     (frame_cmd),
        .frame_len     (frame_len),
        .frame_payload (frame_payload),
        .frame_error   (frame_error),
        .error_code    (error_code),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;
    int nv     = 0;
    int ne     = 0;
    logic both_seen = 1'b0;

    always @(negedge clk) begin
        if (frame_valid) nv <= nv + 1;
        if (frame_error) ne <= ne + 1;
        if (frame_valid && frame_error) both_seen <= 1'b1;
    end

    typedef struct {
        int          n;
        logic [95:0] b;      // first byte in the most significant used position
        int          gap;
        int          exp_v;
        int          exp_e;
        logic [2:0]  code;
        logic [7:0]  cmd;
        logic [3:0]  len;
        logic [63:0] pay;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) tick();
        tick();
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_seq(input int n, input logic [95:0] b, input int gap);
        for (int k = 0; k < n; k++) send_byte(b[8*(n-1-k) +: 8], gap);
    endtask

    task automatic check_frame(input string name, input logic [2:0] code,
                               input logic [7:0] cmd, input logic [3:0] len,
                               input logic [63:0] pay);
        chk({name, ".code"}, 64'(error_code), 64'(code));
        chk({name, ".cmd"}, 64'(frame_cmd), 64'(cmd));
        chk({name, ".len"}, 64'(frame_len), 64'(len));
        chk({name, ".payload"}, frame_payload, pay);
    endtask

    initial begin
        int nv0, ne0;
        vecs[0] = '{7,  96'hA5_10_03_11_22_33_13, 1000, 1, 0, 3'd0, 8'h10, 4'd3,
                    64'h0000_0000_0033_2211};
        vecs[1] = '{6,  96'h00_FF_A5_20_00_20, 0, 1, 0, 3'd0, 8'h20, 4'd0, 64'h0};
        vecs[2] = '{3,  96'hA5_10_09, 3, 0, 1, 3'd1, 8'h20, 4'd0, 64'h0};
        vecs[3] = '{6,  96'hA5_30_02_AA_55_CD, 0, 1, 0, 3'd0, 8'h30, 4'd2, 64'h55AA};
        vecs[4] = '{5,  96'hA5_10_01_55_00, 2, 0, 1, 3'd2, 8'h30, 4'd2, 64'h55AA};
        vecs[5] = '{12, 96'hA5_7E_08_01_02_03_04_05_06_07_08_7E, 0, 1, 0, 3'd0, 8'h7E,
                    4'd8, 64'h0807_0605_0403_0201};
        vecs[6] = '{5,  96'hA5_A5_01_A5_01, 1, 1, 0, 3'd0, 8'hA5, 4'd1, 64'hA5};

        rstb = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; rx_error = 2'd0;
        tick(); tick();
        chk("reset.valid", 64'(frame_valid), 64'd0);
        chk("reset.error", 64'(frame_error), 64'd0);
        chk("reset.busy", 64'(busy), 64'd0);
        check_frame("reset", 3'd0, 8'h00, 4'd0, 64'h0);
        rstb = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            nv0 = nv; ne0 = ne;
            send_seq(vecs[i].n, vecs[i].b, vecs[i].gap);
            chk($sformatf("vec%0d.valid", i), 64'(frame_valid), 64'(vecs[i].exp_v));
            chk($sformatf("vec%0d.error", i), 64'(frame_error), 64'(vecs[i].exp_e));
            chk($sformatf("vec%0d.busy", i), 64'(busy), 64'd0);
            check_frame($sformatf("vec%0d", i), vecs[i].code, vecs[i].cmd, vecs[i].len,
                        vecs[i].pay);
            tick();
            chk($sformatf("vec%0d.width", i), 64'({frame_valid, frame_error}), 64'd0);
            chk($sformatf("vec%0d.nvalid", i), 64'(nv - nv0), 64'(vecs[i].exp_v));
            chk($sformatf("vec%0d.nerror", i), 64'(ne - ne0), 64'(vecs[i].exp_e));
        end

        // Timeout fires T cycles after the last byte, one cycle of latency.
        ne0 = ne;
        send_seq(4, 96'hA5_10_02_11, 0);
        repeat (T) tick();
        chk("tmo.early", 64'(frame_error), 64'd0);
        chk("tmo.busy_before", 64'(busy), 64'd1);
        tick();
        chk("tmo.error", 64'(frame_error), 64'd1);
        chk("tmo.busy_after", 64'(busy), 64'd0);
        check_frame("tmo", 3'd4, 8'hA5, 4'd1, 64'hA5);
        tick();
        chk("tmo.width", 64'(frame_error), 64'd0);
        chk("tmo.nerror", 64'(ne - ne0), 64'd1);

        // Receiver error mid-frame.
        send_seq(4, 96'hA5_10_02_11, 0);
        tick();
        rx_error = 2'd2;
        tick();
        rx_error = 2'd0;
        chk("rxerr.error", 64'(frame_error), 64'd1);
        chk("rxerr.code", 64'(error_code), 64'd3);
        chk("rxerr.busy", 64'(busy), 64'd0);

        // Receiver error is ignored in SYNC; the SYNC byte is still taken.
        ne0 = ne;
        rx_error = 2'd1;
        send_byte(8'hA5, 1);
        chk("rxsync.busy", 64'(busy), 64'd1);
        rx_error = 2'd0;
        send_seq(3, 96'h10_00_10, 0);
        chk("rxsync.valid", 64'(frame_valid), 64'd1);
        check_frame("rxsync", 3'd0, 8'h10, 4'd0, 64'h0);
        chk("rxsync.nerror", 64'(ne - ne0), 64'd0);

        // Byte arriving in the cycle the timeout would expire is accepted.
        ne0 = ne;
        send_seq(3, 96'hA5_10_01, 0);
        send_byte(8'h55, T - 1);
        send_byte(8'h44, 0);
        chk("edge.valid", 64'(frame_valid), 64'd1);
        check_frame("edge", 3'd0, 8'h10, 4'd1, 64'h55);
        chk("edge.nerror", 64'(ne - ne0), 64'd0);

        // One cycle later the timeout wins and the late byte is dropped.
        ne0 = ne;
        send_seq(3, 96'hA5_10_01, 0);
        send_byte(8'h55, T);
        chk("late.nerror", 64'(ne - ne0), 64'd1);
        chk("late.busy", 64'(busy), 64'd0);
        check_frame("late", 3'd4, 8'h10, 4'd1, 64'h55);

        // Reset mid-payload clears everything without an error pulse.
        ne0 = ne;
        send_seq(4, 96'hA5_10_03_11, 0);
        rstb = 1'b0;
        tick();
        chk("rst.valid", 64'(frame_valid), 64'd0);
        chk("rst.error", 64'(frame_error), 64'd0);
        chk("rst.busy", 64'(busy), 64'd0);
        check_frame("rst", 3'd0, 8'h00, 4'd0, 64'h0);
        rstb = 1'b1;
        tick();
        chk("rst.nerror", 64'(ne - ne0), 64'd0);
        send_seq(7, 96'hA5_10_03_11_22_33_13, 0);
        chk("rst.after_valid", 64'(frame_valid), 64'd1);
        check_frame("rst.after", 3'd0, 8'h10, 4'd3, 64'h33_2211);

        chk("never_both", 64'(both_seen), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
